// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared encodings and helpers for the duty waveform generator
package wave_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'b00,
    WAVE_SAW    = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_DC     = 2'b11
  } wave_mode_e;

  localparam int CLIP_W = 2;

  // 100 % duty is half the code space so the PWM stage can compare directly.
  function automatic int full_scale(input int duty_w);
    return 1 << (duty_w - 1);
  endfunction

endpackage

// File: rtl/duty_prescaler.sv
// rtl/duty_prescaler.sv - divides sysclk down to one sample tick every PRESCALE cycles
module duty_prescaler #(
  parameter int PRESCALE = 64
) (
  input  logic sysclk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic             last;

  assign last = (count_q == CNT_W'(PRESCALE - 1));
  assign tick = enable && last;

  always_comb begin
    count_d = count_q + 1'b1;
    if (!enable || last) begin
      count_d = '0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/waveform_duty_generator.sv
// rtl/waveform_duty_generator.sv - phase-accumulator duty source with square/saw/triangle/DC shapes
module waveform_duty_generator
  import wave_pkg::*;
#(
  parameter int DUTY_W   = 7,
  parameter int PHASE_W  = 12,
  parameter int PRESCALE = 64
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [PHASE_W-1:0] sq_thresh,
  input  logic [CLIP_W-1:0]  clip,
  output logic [DUTY_W-1:0]  duty_out,
  output logic               sample_stb,
  output logic               wrap_stb
);

  localparam logic [DUTY_W-1:0] FS_V = DUTY_W'(full_scale(DUTY_W));

  logic               tick;
  logic               carry;
  logic [PHASE_W-1:0] phase_q, phase_d;
  wave_mode_e         mode_q, mode_d;
  logic [CLIP_W-1:0]  clip_q, clip_d;
  logic [PHASE_W-1:0] sq_thr_q, sq_thr_d;
  logic [DUTY_W-2:0]  tri_t;
  logic [DUTY_W-1:0]  raw;
  logic [DUTY_W-1:0]  duty_d;

  duty_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .sysclk(sysclk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  // The sample is shaped from the post-tick phase and settings so it leaves one cycle after the tick.
  always_comb begin
    {carry, phase_d} = {1'b0, phase_q} + {1'b0, freq_word};
    mode_d   = mode_q;
    clip_d   = clip_q;
    sq_thr_d = sq_thr_q;
    if (!enable || (tick && carry)) begin
      mode_d   = wave_mode_e'(mode);
      clip_d   = clip;
      sq_thr_d = sq_thresh;
    end
    tri_t = phase_d[PHASE_W-2 -: DUTY_W-1];
    case (mode_d)
      WAVE_SQUARE: raw = (phase_d < sq_thr_d) ? FS_V : '0;
      WAVE_SAW:    raw = {1'b0, phase_d[PHASE_W-1 -: DUTY_W-1]};
      WAVE_TRI:    raw = {1'b0, (phase_d[PHASE_W-1] ? ~tri_t : tri_t)};
      default:     raw = FS_V;
    endcase
    duty_d = raw >> clip_d;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      phase_q    <= '0;
      mode_q     <= WAVE_SQUARE;
      clip_q     <= '0;
      sq_thr_q   <= {1'b1, {(PHASE_W-1){1'b0}}};
      duty_out   <= '0;
      sample_stb <= 1'b0;
      wrap_stb   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      clip_q   <= clip_d;
      sq_thr_q <= sq_thr_d;
      if (!enable) begin
        phase_q    <= '0;
        duty_out   <= '0;
        sample_stb <= 1'b0;
        wrap_stb   <= 1'b0;
      end else if (tick) begin
        phase_q    <= phase_d;
        duty_out   <= duty_d;
        sample_stb <= 1'b1;
        wrap_stb   <= carry;
      end else begin
        sample_stb <= 1'b0;
        wrap_stb   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_waveform_duty_generator.sv
// tb/tb_waveform_duty_generator.sv - scoreboard bench for waveform_duty_generator
module tb_waveform_duty_generator;

  localparam int DUTY_W   = 7;
  localparam int PHASE_W  = 8;
  localparam int PRESCALE = 4;
  localparam int FS       = 64;
  localparam int PMOD     = 256;

  logic              sysclk = 1'b0;
  logic              reset;
  logic              enable;
  logic [1:0]        mode;
  logic [PHASE_W-1:0] freq_word;
  logic [PHASE_W-1:0] sq_thresh;
  logic [1:0]        clip;
  logic [DUTY_W-1:0] duty_out;
  logic              sample_stb;
  logic              wrap_stb;

  waveform_duty_generator #(
    .DUTY_W  (DUTY_W),
    .PHASE_W (PHASE_W),
    .PRESCALE(PRESCALE)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .freq_word (freq_word),
    .sq_thresh (sq_thresh),
    .clip      (clip),
    .duty_out  (duty_out),
    .sample_stb(sample_stb),
    .wrap_stb  (wrap_stb)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int duty;
    bit wrap;
    int stamp;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  int m_cnt, m_phase, m_mode, m_clip, m_thr;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wave_value(input int md, input int ph, input int thr, input int cl);
    int v;
    case (md)
      0:       v = (ph < thr) ? FS : 0;
      1:       v = (ph * FS) / PMOD;
      2:       v = (ph < PMOD / 2) ? ph / 2 : (PMOD / 2 - 1) - ph / 2;
      default: v = FS;
    endcase
    return v >> cl;
  endfunction

  task automatic model_step();
    exp_t e;
    int   sum;
    if (reset) begin
      m_cnt = 0; m_phase = 0; m_mode = 0; m_clip = 0; m_thr = PMOD / 2;
    end else if (!enable) begin
      m_cnt = 0; m_phase = 0;
      m_mode = int'(mode); m_clip = int'(clip); m_thr = int'(sq_thresh);
    end else begin
      m_cnt++;
      if (m_cnt == PRESCALE) begin
        m_cnt   = 0;
        sum     = m_phase + int'(freq_word);
        e.wrap  = (sum >= PMOD);
        m_phase = sum % PMOD;
        if (e.wrap) begin
          m_mode = int'(mode); m_clip = int'(clip); m_thr = int'(sq_thresh);
        end
        e.duty  = wave_value(m_mode, m_phase, m_thr, m_clip);
        e.stamp = cyc + 1;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic step();
    model_step();
    @(negedge sysclk);
  endtask

  task automatic run_samples(input int n);
    repeat (n * PRESCALE) step();
  endtask

  task automatic reload(input int md, input int fw, input int thr, input int cl);
    enable    = 1'b0;
    mode      = md[1:0];
    freq_word = fw[PHASE_W-1:0];
    sq_thresh = thr[PHASE_W-1:0];
    clip      = cl[1:0];
    step();
    step();
    enable = 1'b1;
  endtask

  always @(negedge sysclk) begin
    if (sample_stb === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_sample", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("sample_time", cyc, mon_e.stamp);
        check("duty", int'(duty_out), mon_e.duty);
        check("wrap_stb", int'(wrap_stb), int'(mon_e.wrap));
      end
    end else if (wrap_stb !== 1'b0) begin
      check("wrap_without_sample", int'(wrap_stb), 0);
    end
  end

  initial begin
    int guard;
    reset     = 1'b1;
    enable    = 1'b1;
    mode      = 2'b00;
    freq_word = 8'd1;
    sq_thresh = 8'd128;
    clip      = 2'd0;

    repeat (3) begin
      step();
      check("reset_duty", int'(duty_out), 0);
      check("reset_sample_stb", int'(sample_stb), 0);
      check("reset_wrap_stb", int'(wrap_stb), 0);
    end
    reset = 1'b0;

    // square, threshold at half scale, one full period plus a few samples
    run_samples(260);

    reload(1, 4, 128, 0);
    run_samples(70);
    reload(1, 4, 128, 2);
    run_samples(70);

    reload(2, 2, 128, 0);
    run_samples(130);

    // mid-period change only lands at the next wrap
    reload(1, 4, 128, 0);
    run_samples(20);
    mode = 2'b11;
    clip = 2'd1;
    run_samples(60);

    // enable falls exactly on a tick cycle
    reload(1, 4, 128, 0);
    run_samples(3);
    guard = 0;
    while (m_cnt != PRESCALE - 1 && guard < 10) begin
      step();
      guard++;
    end
    check("tick_align_guard", int'(guard < 10), 1);
    enable = 1'b0;
    mode   = 2'b11;
    clip   = 2'd0;
    step();
    check("drop_duty", int'(duty_out), 0);
    check("drop_sample_stb", int'(sample_stb), 0);
    enable = 1'b1;
    run_samples(3);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) freq_word = 8'($urandom);
      if ($urandom_range(0, 3) == 0) mode      = 2'($urandom);
      if ($urandom_range(0, 3) == 0) clip      = 2'($urandom);
      if ($urandom_range(0, 3) == 0) sq_thresh = 8'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      reset  = ($urandom_range(0, 24) == 0);
      repeat ($urandom_range(1, 24)) step();
      reset = 1'b0;
    end

    enable = 1'b0;
    step();
    step();
    check("queue_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
